// File: rtl/layer_feeder_pkg.sv
// Shared types and defaults for the layer feeder family: FSM encoding,
// default geometry, and an a_bus element extraction helper.
package layer_feeder_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    OUT  = 2'd2
  } feeder_state_t;

  localparam int unsigned DEF_DW      = 8;
  localparam int unsigned DEF_NUM_IN  = 10;
  localparam int unsigned DEF_LATENCY = 3;

  // Element idx of a default-geometry activation bus (element 0 in the LSBs).
  function automatic logic [DEF_DW-1:0] bus_elem(
    input logic [DEF_NUM_IN*DEF_DW-1:0] bus,
    input int unsigned                  idx
  );
    return DEF_DW'(bus >> (idx * DEF_DW));
  endfunction

endpackage

// File: rtl/feeder_hold_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module feeder_hold_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && !done) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/layer_feeder.sv
// Deserialises a byte stream into a parallel activation vector for one node,
// waits out the node pipeline, then returns the node result on a stream.
module layer_feeder
  import layer_feeder_pkg::*;
#(
  parameter int unsigned NUM_IN  = DEF_NUM_IN,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [NUM_IN*DW-1:0] a_bus,
  input  logic [DW-1:0]        node_result,
  output logic [DW-1:0]        m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 err_frame
);

  localparam int unsigned   CW        = $clog2(NUM_IN + 1);
  localparam int unsigned   HW        = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_IN - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(LATENCY);

  feeder_state_t         state;
  feeder_state_t         state_next;
  logic [CW-1:0]         count;
  logic [DW-1:0]         shadow [NUM_IN];
  logic [NUM_IN*DW-1:0]  frame_next;
  logic                  beat;
  logic                  commit;
  logic                  capture;
  logic                  hold_done;

  feeder_hold_timer #(.W(HW)) u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (commit),
    .load_value (HOLD_LOAD),
    .en         (state == HOLD),
    .done       (hold_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    beat       = s_valid && s_ready && (state == FILL);
    commit     = beat && (s_last || (count == LAST_IDX));
    capture    = 1'b0;
    state_next = state;
    unique case (state)
      FILL: if (commit) state_next = HOLD;
      HOLD: begin
        if (hold_done) begin
          capture    = 1'b1;
          state_next = OUT;
        end
      end
      OUT:  if (m_ready) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Committed frame: stored beats below count, the live beat at count, zeros above.
  always_comb begin
    frame_next = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (CW'(i) < count) begin
        frame_next[i*DW +: DW] = shadow[i];
      end else if (CW'(i) == count) begin
        frame_next[i*DW +: DW] = s_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      a_bus     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      s_ready   <= 1'b0;
      err_frame <= 1'b0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      s_ready   <= (state_next == FILL);
      err_frame <= commit && !(s_last && (count == LAST_IDX));
      if (commit) begin
        count <= '0;
        a_bus <= frame_next;
      end else if (beat) begin
        count <= count + 1'b1;
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (beat && (count == CW'(i))) begin
          shadow[i] <= s_data;
        end
      end
      if (capture) begin
        m_data  <= node_result;
        m_valid <= 1'b1;
      end else if ((state == OUT) && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != FILL) || (count != '0);

endmodule

// File: tb/tb_layer_feeder.sv
// Directed bench for layer_feeder with a 3-stage delay stub standing in for the node.
`timescale 1ns/1ps
module tb_layer_feeder;
  import layer_feeder_pkg::*;

  localparam int unsigned NUM_IN  = 10;
  localparam int unsigned LATENCY = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [79:0] a_bus;
  logic [7:0]  node_result;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        err_frame;

  int unsigned tests = 0;
  int unsigned fails = 0;

  layer_feeder #(.NUM_IN(NUM_IN), .DW(8), .LATENCY(LATENCY)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .a_bus       (a_bus),
    .node_result (node_result),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .err_frame   (err_frame)
  );

  always #5 clk = ~clk;

  // Node stub: three register stages on element 0.
  logic [7:0] n1, n2, n3;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n1 <= '0; n2 <= '0; n3 <= '0;
    end else begin
      n1 <= bus_elem(a_bus, 0);
      n2 <= n1;
      n3 <= n2;
    end
  end
  assign node_result = n3;

  typedef struct {
    logic [95:0] bytes;
    int unsigned nbeats;
    logic        last;
    logic [79:0] exp_bus;
    logic        exp_err;
    logic [7:0]  exp_m;
    int unsigned stall;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_beat(input logic [7:0] d, input logic l, input string tag);
    int unsigned w = 0;
    s_data = d; s_valid = 1'b1; s_last = l;
    while (!s_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    check({tag, " s_ready wait"}, 80'(s_ready), 80'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_commit(input logic [79:0] exp_bus, input logic exp_err, input string tag);
    check({tag, " a_bus"},     a_bus,           exp_bus);
    check({tag, " err_frame"}, 80'(err_frame),  80'(exp_err));
    check({tag, " s_ready"},   80'(s_ready),    80'(0));
    check({tag, " busy"},      80'(busy),       80'(1));
  endtask

  task automatic collect(input logic [7:0] exp_m, input string tag);
    int unsigned cyc  = 0;
    int unsigned errs = 0;
    while (!m_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (err_frame) errs++;
    end
    check({tag, " latency"},     80'(cyc),    80'(LATENCY + 1));
    check({tag, " m_data"},      80'(m_data), 80'(exp_m));
    check({tag, " err pulses"},  80'(errs),   80'(0));
  endtask

  task automatic drain(input string tag);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check({tag, " m_valid drop"}, 80'(m_valid), 80'(0));
    check({tag, " s_ready back"}, 80'(s_ready), 80'(1));
    check({tag, " busy idle"},    80'(busy),    80'(0));
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    for (int unsigned j = 0; j < v.nbeats; j++) begin
      do_beat(8'(v.bytes >> (j * 8)), v.last && (j == v.nbeats - 1), tag);
    end
    check_commit(v.exp_bus, v.exp_err, tag);
    collect(v.exp_m, tag);
    m_ready = 1'b0;
    for (int unsigned k = 0; k < v.stall; k++) begin
      @(posedge clk); #1;
      check({tag, " bp m_valid"}, 80'(m_valid), 80'(1));
      check({tag, " bp m_data"},  80'(m_data),  80'(v.exp_m));
      check({tag, " bp s_ready"}, 80'(s_ready), 80'(0));
      check({tag, " bp a_bus"},   a_bus,        v.exp_bus);
    end
    drain(tag);
  endtask

  function automatic logic [7:0] tp_byte(input int unsigned g);
    return 8'(g * 13 + 5);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idx, frames, cyc, last_cyc, errs, nready;
    logic        r;
    logic [79:0] exp_bus;

    vecs[0] = '{bytes: 96'h0A090807060504030201, nbeats: 10, last: 1'b1,
                exp_bus: 80'h0A090807060504030201, exp_err: 1'b0, exp_m: 8'h01, stall: 0};
    vecs[1] = '{bytes: 96'h404040, nbeats: 3, last: 1'b1,
                exp_bus: 80'h00000000000000404040, exp_err: 1'b1, exp_m: 8'h40, stall: 0};
    vecs[2] = '{bytes: 96'h89888786858483828180, nbeats: 10, last: 1'b0,
                exp_bus: 80'h89888786858483828180, exp_err: 1'b1, exp_m: 8'h80, stall: 0};
    vecs[3] = '{bytes: 96'hFF, nbeats: 1, last: 1'b1,
                exp_bus: 80'h000000000000000000FF, exp_err: 1'b1, exp_m: 8'hFF, stall: 0};
    vecs[4] = '{bytes: 96'hFFFEFDFCFBFAF9F8F7F6, nbeats: 10, last: 1'b1,
                exp_bus: 80'hFFFEFDFCFBFAF9F8F7F6, exp_err: 1'b0, exp_m: 8'hF6, stall: 20};

    reset = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst a_bus",     a_bus,           80'(0));
    check("rst s_ready",   80'(s_ready),    80'(0));
    check("rst m_valid",   80'(m_valid),    80'(0));
    check("rst m_data",    80'(m_data),     80'(0));
    check("rst err_frame", 80'(err_frame),  80'(0));
    check("rst busy",      80'(busy),       80'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    check("post-rst s_ready", 80'(s_ready), 80'(1));

    for (int unsigned v = 0; v < 5; v++) begin
      run_vector(vecs[v], $sformatf("vec%0d", v));
    end

    // Missing s_last: 12 beats offered, the last two are stalled into the next frame.
    for (int unsigned j = 0; j < 10; j++) begin
      do_beat(8'(8'hA0 + j), 1'b0, "nolast");
    end
    check_commit(80'hA9A8A7A6A5A4A3A2A1A0, 1'b1, "nolast");
    s_data = 8'h55; s_valid = 1'b1; s_last = 1'b0;
    cyc = 0; nready = 0;
    while (!m_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (s_ready) nready++;
    end
    check("nolast hold s_ready", 80'(nready), 80'(0));
    check("nolast m_data",       80'(m_data), 80'(8'hA0));
    drain("nolast");
    do_beat(8'h55, 1'b0, "nolast2");
    do_beat(8'h66, 1'b1, "nolast2");
    check_commit(80'h6655, 1'b1, "nolast2");
    collect(8'h55, "nolast2");
    drain("nolast2");

    // Asynchronous reset in the middle of HOLD.
    for (int unsigned j = 0; j < 10; j++) begin
      do_beat(8'(8'hC0 + j), j == 9, "rsthold");
    end
    check_commit(80'hC9C8C7C6C5C4C3C2C1C0, 1'b0, "rsthold");
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("rsthold a_bus",   a_bus,          80'(0));
    check("rsthold m_valid", 80'(m_valid),   80'(0));
    check("rsthold m_data",  80'(m_data),    80'(0));
    check("rsthold s_ready", 80'(s_ready),   80'(0));
    check("rsthold err",     80'(err_frame), 80'(0));
    check("rsthold busy",    80'(busy),      80'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rsthold s_ready back", 80'(s_ready), 80'(1));
    run_vector(vecs[0], "after_rst");

    // Throughput: continuous source and sink over 100 frames.
    idx = 0; frames = 0; cyc = 0; last_cyc = 0; errs = 0;
    m_ready = 1'b1; s_valid = 1'b1; s_data = tp_byte(0); s_last = 1'b0;
    while (frames < 100 && cyc < 4000) begin
      r = s_ready && s_valid;
      @(posedge clk); #1; cyc++;
      if (err_frame) errs++;
      if (r) begin
        idx++;
        if (idx == 1000) s_valid = 1'b0;
        s_data = tp_byte(idx);
        s_last = (idx % 10 == 9);
      end
      if (m_valid) begin
        exp_bus = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
          exp_bus = exp_bus | (80'(tp_byte(frames * 10 + i)) << (i * 8));
        end
        check($sformatf("tp%0d a_bus", frames), a_bus, exp_bus);
        check($sformatf("tp%0d m_data", frames), 80'(m_data), 80'(tp_byte(frames * 10)));
        if (frames > 0) begin
          check($sformatf("tp%0d period", frames), 80'(cyc - last_cyc), 80'(NUM_IN + LATENCY + 2));
        end
        last_cyc = cyc;
        frames++;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    check("tp frames", 80'(frames), 80'(100));
    check("tp bytes",  80'(idx),    80'(1000));
    check("tp errs",   80'(errs),   80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
